fir_mac_sequencer: RTL

Controller that time-multiplexes one shared 1-adder/1-multiplier FIR MAC across NTAP taps. It performs these steps:
- Accepts input samples on an AXI-Stream-style slave port.
- Maintains a circular data buffer in an external RAM.
- Walks the tap RAM and data RAM in lockstep while driving the MAC.
- Returns each filtered sample on a master stream port.
A run is started with ap_start and processes data_length samples.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_ring_addr.sv | 60 ++++++
 rtl/fir_mac_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_pkg                                                               |
// | Shared defaults, FSM state encoding and ring-buffer helper for the    |
// | FIR MAC sequencer.                                                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fir_pkg;

    localparam int c_NTAP = 11;
    localparam int c_DW   = 32;
    localparam int c_AW   = 4;

    typedef logic [2:0] fir_state_t;

    localparam fir_state_t c_IDLE = 3'd0;
    localparam fir_state_t c_INIT = 3'd1;
    localparam fir_state_t c_WAIT = 3'd2;
    localparam fir_state_t c_MAC  = 3'd3;
    localparam fir_state_t c_OUT  = 3'd4;

    // (a - b) mod n for operands already reduced into 0..n-1
    function automatic int unsigned ring_dec(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        return (a >= b) ? (a - b) : (a + n - b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_ring_addr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_ring_addr                                                         |
// | Circular-buffer write pointer and tap-index generator for the FIR     |
// | MAC walk.                                                             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fir_ring_addr
    import fir_pkg::*;
#(
    parameter int NTAP = c_NTAP,
    parameter int AW   = c_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          mac_en,
    input  logic          wp_inc,
    output logic [AW-1:0] wp,
    output logic          k_last,
    output logic [AW-1:0] tap_addr,
    output logic [AW-1:0] data_addr
);

    localparam int KW = $clog2(NTAP + 1);
    localparam logic [KW-1:0] c_KLAST = KW'(NTAP);
    localparam logic [AW-1:0] c_WPMAX = AW'(NTAP - 1);

    logic [KW-1:0] r_k;
    logic [AW-1:0] r_wp;
    logic          w_k_last;

    assign w_k_last = (r_k == c_KLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k  <= '0;
            r_wp <= '0;
        end else begin
            if (clr) begin
                r_wp <= '0;
            end else if (wp_inc) begin
                r_wp <= (r_wp == c_WPMAX) ? '0 : r_wp + 1'b1;
            end
            // k free-runs 0..NTAP while the MAC is enabled, then parks at 0
            if (mac_en && !w_k_last) begin
                r_k <= r_k + 1'b1;
            end else begin
                r_k <= '0;
            end
        end
    end

    assign wp        = r_wp;
    assign k_last    = w_k_last;
    assign tap_addr  = w_k_last ? '0 : AW'(r_k);
    assign data_addr = w_k_last ? '0 : AW'(ring_dec(32'(r_wp), 32'(r_k), 32'(NTAP)));

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_mac_sequencer                                                     |
// | Streams samples through a shared single-MAC FIR, managing the data    |
// | ring buffer in external RAM and sequencing the tap walk.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAP = c_NTAP,
    parameter int DW   = c_DW,
    parameter int AW   = c_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ap_start,
    input  logic [31:0]   data_length,
    output logic          ap_idle,
    output logic          ap_done,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    output logic          ss_tready,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    output logic          sm_tlast,
    input  logic          sm_tready,
    output logic [AW-1:0] tap_addr,
    input  logic [DW-1:0] tap_do,
    output logic          data_we,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_di,
    input  logic [DW-1:0] data_do,
    output logic [DW-1:0] mac_x,
    output logic [DW-1:0] mac_coe,
    output logic          mac_valid,
    input  logic [DW-1:0] mac_y,
    input  logic          mac_done,
    output logic          err
);

    localparam logic [AW-1:0] c_INIT_LAST = AW'(NTAP - 1);

    fir_state_t    r_state;
    logic [31:0]   r_len;
    logic [31:0]   r_count;
    logic [AW-1:0] r_init;
    logic [DW-1:0] r_tdata;
    logic          r_done;
    logic          r_err;

    logic          w_init_last;
    logic          w_k_last;
    logic [AW-1:0] w_wp;
    logic [AW-1:0] w_ring_tap;
    logic [AW-1:0] w_ring_data;

    assign w_init_last = (r_init == c_INIT_LAST);

    fir_ring_addr #(
        .NTAP (NTAP),
        .AW   (AW)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clr       ((r_state == c_INIT) && w_init_last),
        .mac_en    (r_state == c_MAC),
        .wp_inc    ((r_state == c_MAC) && w_k_last),
        .wp        (w_wp),
        .k_last    (w_k_last),
        .tap_addr  (w_ring_tap),
        .data_addr (w_ring_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_len   <= '0;
            r_count <= '0;
            r_init  <= '0;
            r_tdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (ap_start) begin
                        r_len   <= data_length;
                        r_init  <= '0;
                        r_state <= c_INIT;
                    end
                end
                c_INIT: begin
                    if (w_init_last) begin
                        r_count <= '0;
                        if (r_len == 32'd0) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_WAIT;
                        end
                    end else begin
                        r_init <= r_init + 1'b1;
                    end
                end
                c_WAIT: begin
                    if (ss_tvalid) begin
                        r_state <= c_MAC;
                    end
                end
                c_MAC: begin
                    // The MAC's result is only valid on the window's last cycle
                    if (w_k_last) begin
                        r_tdata <= mac_y;
                        if (!mac_done) begin
                            r_err <= 1'b1;
                        end
                        r_state <= c_OUT;
                    end
                end
                c_OUT: begin
                    if (sm_tready) begin
                        r_count <= r_count + 32'd1;
                        if (r_count + 32'd1 == r_len) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_WAIT;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        data_we   = 1'b0;
        data_addr = '0;
        data_di   = '0;
        tap_addr  = '0;
        case (r_state)
            c_INIT: begin
                data_we   = 1'b1;
                data_addr = r_init;
            end
            c_WAIT: begin
                data_we   = ss_tvalid;
                data_addr = w_wp;
                data_di   = ss_tdata;
            end
            c_MAC: begin
                data_addr = w_ring_data;
                tap_addr  = w_ring_tap;
            end
            default: ;
        endcase
    end

    assign ap_idle   = (r_state == c_IDLE);
    assign ap_done   = r_done;
    assign ss_tready = (r_state == c_WAIT);
    assign sm_tvalid = (r_state == c_OUT);
    assign sm_tdata  = r_tdata;
    assign sm_tlast  = (r_state == c_OUT) && (r_count == r_len - 32'd1);
    assign mac_x     = data_do;
    assign mac_coe   = tap_do;
    assign mac_valid = (r_state == c_MAC);
    assign err       = r_err;

endmodule
`default_nettype wire
